id_ex_alu_issue: RTL and testbench

ID/EX issue stage that drives the ALU: decodes each MIPS instruction into the 3-bit ALU operation code, selects and forwards operands, and registers them for the execute cycle. It produces the `alu_control`/`a`/`b` triple the ALU consumes. It also provides EX/MEM forwarding, MEM/WB forwarding, load-use bubble insertion, and stall/flush control.

---
 rtl/id_ex_alu_issue.sv | 165 ++++++++++++++++
 tb/tb_id_ex_alu_issue.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_alu_issue.sv
// ID/EX issue stage: decodes MIPS instructions into ALU op codes, forwards operands
// from EX/MEM and MEM/WB, inserts load-use bubbles and registers the execute-cycle bundle.
module id_ex_alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        stall,
    input  logic        flush,
    input  logic        exmem_we,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_data,
    input  logic        memwb_we,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_data,
    output logic [2:0]  alu_control,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [31:0] store_data,
    output logic [4:0]  dest_reg,
    output logic        valid_out,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch_eq,
    output logic        branch_ne,
    output logic        illegal,
    output logic        load_use
);

    logic [5:0]  opcode, funct;
    logic [4:0]  rs_idx, rt_idx, rd_idx;
    logic [31:0] imm_s, imm_z;
    logic [31:0] fwd_rs, fwd_rt;

    logic        dec_legal, dec_rw, dec_mr, dec_mw, dec_beq, dec_bne, reads_rt;
    logic [2:0]  dec_op;
    logic [31:0] dec_b, dec_store;
    logic [4:0]  dec_dest;

    assign opcode = instr[31:26];
    assign rs_idx = instr[25:21];
    assign rt_idx = instr[20:16];
    assign rd_idx = instr[15:11];
    assign funct  = instr[5:0];
    assign imm_s  = {{16{instr[15]}}, instr[15:0]};
    assign imm_z  = {16'd0, instr[15:0]};

    // EX/MEM is the younger result, so it takes priority over MEM/WB.
    assign fwd_rs = (exmem_we && exmem_rd == rs_idx && rs_idx != 5'd0) ? exmem_data :
                    (memwb_we && memwb_rd == rs_idx && rs_idx != 5'd0) ? memwb_data : rs_data;
    assign fwd_rt = (exmem_we && exmem_rd == rt_idx && rt_idx != 5'd0) ? exmem_data :
                    (memwb_we && memwb_rd == rt_idx && rt_idx != 5'd0) ? memwb_data : rt_data;

    always_comb begin
        dec_legal = 1'b1;
        dec_op    = 3'd0;
        dec_b     = fwd_rt;
        dec_dest  = rt_idx;
        dec_rw    = 1'b1;
        dec_mr    = 1'b0;
        dec_mw    = 1'b0;
        dec_beq   = 1'b0;
        dec_bne   = 1'b0;
        dec_store = 32'd0;
        reads_rt  = 1'b0;
        case (opcode)
            6'h00: begin
                reads_rt = 1'b1;
                dec_dest = rd_idx;
                case (funct)
                    6'h20, 6'h21: dec_op = 3'd0;
                    6'h22, 6'h23: dec_op = 3'd1;
                    6'h24:        dec_op = 3'd2;
                    6'h25:        dec_op = 3'd4;
                    6'h26:        dec_op = 3'd5;
                    6'h27:        dec_op = 3'd3;
                    6'h2A:        dec_op = 3'd6;
                    default:      dec_legal = 1'b0;
                endcase
            end
            6'h08, 6'h09: dec_b = imm_s;
            6'h0A: begin dec_op = 3'd6; dec_b = imm_s; end
            6'h0C: begin dec_op = 3'd2; dec_b = imm_z; end
            6'h0D: begin dec_op = 3'd4; dec_b = imm_z; end
            6'h0E: begin dec_op = 3'd5; dec_b = imm_z; end
            6'h23: begin dec_b = imm_s; dec_mr = 1'b1; end
            6'h2B: begin
                dec_b     = imm_s;
                dec_mw    = 1'b1;
                dec_rw    = 1'b0;
                dec_dest  = 5'd0;
                dec_store = fwd_rt;
                reads_rt  = 1'b1;
            end
            6'h04, 6'h05: begin
                dec_op   = 3'd1;
                dec_rw   = 1'b0;
                dec_dest = 5'd0;
                dec_beq  = (opcode == 6'h04);
                dec_bne  = (opcode == 6'h05);
                reads_rt = 1'b1;
            end
            default: begin
                dec_legal = 1'b0;
                dec_rw    = 1'b0;
                dec_dest  = 5'd0;
            end
        endcase
    end

    assign load_use = valid_in && valid_out && mem_read && dest_reg != 5'd0 &&
                      (dest_reg == rs_idx || (reads_rt && dest_reg == rt_idx));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_control <= 3'd0;
            alu_a       <= 32'd0;
            alu_b       <= 32'd0;
            store_data  <= 32'd0;
            dest_reg    <= 5'd0;
            valid_out   <= 1'b0;
            reg_write   <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            branch_eq   <= 1'b0;
            branch_ne   <= 1'b0;
            illegal     <= 1'b0;
        end else if (flush || !stall) begin
            // Everything not captured below collapses to a bubble.
            alu_control <= 3'd0;
            alu_a       <= 32'd0;
            alu_b       <= 32'd0;
            store_data  <= 32'd0;
            dest_reg    <= 5'd0;
            valid_out   <= 1'b0;
            reg_write   <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            branch_eq   <= 1'b0;
            branch_ne   <= 1'b0;
            illegal     <= 1'b0;
            if (!flush && !load_use && valid_in) begin
                if (dec_legal) begin
                    alu_control <= dec_op;
                    alu_a       <= fwd_rs;
                    alu_b       <= dec_b;
                    store_data  <= dec_store;
                    dest_reg    <= dec_dest;
                    valid_out   <= 1'b1;
                    reg_write   <= dec_rw;
                    mem_read    <= dec_mr;
                    mem_write   <= dec_mw;
                    branch_eq   <= dec_beq;
                    branch_ne   <= dec_bne;
                end else begin
                    illegal <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Self-checking bench for id_ex_alu_issue: directed scenarios plus randomized
// instruction streams compared against a behavioural model of the stage.
module tb_id_ex_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, stall, flush, exmem_we, memwb_we;
    logic [31:0] instr, rs_data, rt_data, exmem_data, memwb_data;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [2:0]  alu_control;
    logic [31:0] alu_a, alu_b, store_data;
    logic [4:0]  dest_reg;
    logic        valid_out, reg_write, mem_read, mem_write, branch_eq, branch_ne, illegal, load_use;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        v;
        logic [2:0]  op;
        logic [31:0] a, b, sd;
        logic [4:0]  dest;
        logic        rw, mr, mw, beq, bne, ill;
    } stage_t;

    stage_t m;

    id_ex_alu_issue dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .instr(instr),
        .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .flush(flush),
        .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
        .store_data(store_data), .dest_reg(dest_reg), .valid_out(valid_out),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .branch_eq(branch_eq), .branch_ne(branch_ne), .illegal(illegal),
        .load_use(load_use)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 0) return rf;
        if (exmem_we && exmem_rd == idx) return exmem_data;
        if (memwb_we && memwb_rd == idx) return memwb_data;
        return rf;
    endfunction

    function automatic logic reads_rt_of(input logic [5:0] opc);
        return opc == 6'h00 || opc == 6'h2B || opc == 6'h04 || opc == 6'h05;
    endfunction

    function automatic logic model_lu();
        logic [4:0] rs = instr[25:21];
        logic [4:0] rt = instr[20:16];
        return valid_in && m.v && m.mr && m.dest != 0 &&
               (m.dest == rs || (reads_rt_of(instr[31:26]) && m.dest == rt));
    endfunction

    // Next stage contents from the instruction's meaning, not the RTL structure.
    function automatic stage_t model_next();
        stage_t n = '0;
        logic [5:0]  opc = instr[31:26];
        logic [5:0]  fn  = instr[5:0];
        logic [31:0] a   = fwd(instr[25:21], rs_data);
        logic [31:0] b   = fwd(instr[20:16], rt_data);
        int          se  = $signed(instr[15:0]);
        int          ze  = int'(instr[15:0]);
        int          op  = -1;
        if (flush) return n;
        if (stall) return m;
        if (model_lu() || !valid_in) return n;
        n.a = a;
        if (opc == 0) begin
            case (fn)
                6'h20, 6'h21: op = 0;
                6'h22, 6'h23: op = 1;
                6'h24: op = 2;
                6'h25: op = 4;
                6'h26: op = 5;
                6'h27: op = 3;
                6'h2A: op = 6;
                default: op = -1;
            endcase
            n.b = b; n.dest = instr[15:11]; n.rw = 1;
        end else if (opc == 6'h08 || opc == 6'h09) begin op = 0; n.b = se; n.dest = instr[20:16]; n.rw = 1; end
        else if (opc == 6'h0A) begin op = 6; n.b = se; n.dest = instr[20:16]; n.rw = 1; end
        else if (opc == 6'h0C) begin op = 2; n.b = ze; n.dest = instr[20:16]; n.rw = 1; end
        else if (opc == 6'h0D) begin op = 4; n.b = ze; n.dest = instr[20:16]; n.rw = 1; end
        else if (opc == 6'h0E) begin op = 5; n.b = ze; n.dest = instr[20:16]; n.rw = 1; end
        else if (opc == 6'h23) begin op = 0; n.b = se; n.dest = instr[20:16]; n.rw = 1; n.mr = 1; end
        else if (opc == 6'h2B) begin op = 0; n.b = se; n.mw = 1; n.sd = b; end
        else if (opc == 6'h04) begin op = 1; n.b = b; n.beq = 1; end
        else if (opc == 6'h05) begin op = 1; n.b = b; n.bne = 1; end
        if (op < 0) begin
            n = '0;
            n.ill = 1;
            return n;
        end
        n.op = 3'(op);
        n.v  = 1;
        return n;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".op"},   32'(alu_control), 32'(m.op));
        check({tag, ".a"},    alu_a, m.a);
        check({tag, ".b"},    alu_b, m.b);
        check({tag, ".sd"},   store_data, m.sd);
        check({tag, ".dest"}, 32'(dest_reg), 32'(m.dest));
        check({tag, ".flags"},
              32'({valid_out, reg_write, mem_read, mem_write, branch_eq, branch_ne, illegal}),
              32'({m.v, m.rw, m.mr, m.mw, m.beq, m.bne, m.ill}));
    endtask

    task automatic set_idle();
        valid_in = 0; instr = 0; rs_data = 0; rt_data = 0; stall = 0; flush = 0;
        exmem_we = 0; exmem_rd = 0; exmem_data = 0;
        memwb_we = 0; memwb_rd = 0; memwb_data = 0;
    endtask

    // Inputs are already driven (after a negedge); check load_use, clock once, check outputs.
    task automatic step(input string tag);
        stage_t nx;
        #1;
        check({tag, ".lu"}, 32'(load_use), 32'(model_lu()));
        nx = model_next();
        @(posedge clk);
        m = nx;
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    initial begin
        logic [5:0] opcs [12];
        logic [5:0] fns  [9];
        opcs = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04};
        fns  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};

        set_idle();
        m = '0;
        rst_n = 0;
        #12;
        check_all("reset");
        rst_n = 1;
        @(negedge clk);

        valid_in = 1; instr = r_ins(1, 2, 3, 6'h20); rs_data = 5; rt_data = 7;
        step("add");
        check("add.a_const", alu_a, 32'd5);
        check("add.b_const", alu_b, 32'd7);

        instr = i_ins(6'h08, 1, 4, 16'hFFFF);
        step("addi");
        check("addi.b_const", alu_b, 32'hFFFF_FFFF);

        instr = i_ins(6'h0D, 1, 4, 16'h8000);
        step("ori");
        check("ori.b_const", alu_b, 32'h0000_8000);

        instr = r_ins(1, 2, 3, 6'h27); step("nor");
        instr = r_ins(1, 2, 3, 6'h2A); step("slt");

        instr = r_ins(2, 1, 3, 6'h20);
        exmem_we = 1; exmem_rd = 2; exmem_data = 32'hAA;
        memwb_we = 1; memwb_rd = 2; memwb_data = 32'hBB;
        step("fwd_ex");
        check("fwd_ex.a_const", alu_a, 32'hAA);
        exmem_rd = 9;
        step("fwd_wb");
        check("fwd_wb.a_const", alu_a, 32'hBB);
        exmem_rd = 0; memwb_rd = 0; instr = r_ins(0, 1, 3, 6'h20); rs_data = 32'h11;
        step("fwd_zero");
        check("fwd_zero.a_const", alu_a, 32'h11);
        exmem_we = 0; memwb_we = 0;

        instr = i_ins(6'h23, 1, 5, 16'd4); step("lw");
        instr = r_ins(5, 2, 6, 6'h22);
        #1 check("lu_assert", 32'(load_use), 32'd1);
        step("lu_bubble");
        check("lu_bubble.v", 32'(valid_out), 32'd0);
        step("lu_issue");
        check("lu_issue.op", 32'(alu_control), 32'd1);

        stall = 1;
        for (int i = 0; i < 3; i++) begin
            instr = r_ins(i + 1, 2, 7, 6'h24);
            step("stall");
            check("stall.op_const", 32'(alu_control), 32'd1);
        end
        flush = 1;
        step("flush_stall");
        flush = 0; stall = 0;

        instr = {6'h3F, 26'h123};
        step("illegal");
        check("illegal.flag", 32'(illegal), 32'd1);
        instr = r_ins(1, 2, 3, 6'h20);
        step("after_illegal");

        @(posedge clk); #2;
        check("pre_reset.v", 32'(valid_out), 32'd1);
        rst_n = 0;
        #1;
        m = '0;
        check_all("async_reset");
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 400; i++) begin
            int sel = $urandom_range(0, 13);
            int rs  = $urandom_range(0, 7);
            int rt  = $urandom_range(0, 7);
            int rd  = $urandom_range(0, 7);
            logic [15:0] imm = 16'($urandom);
            valid_in = ($urandom_range(0, 9) != 0);
            if (sel == 12) instr = {6'($urandom_range(16, 22)), 5'(rs), 5'(rt), imm};
            else if (sel == 13) instr = r_ins(rs, rt, rd, 6'h3E);
            else if (opcs[sel] == 6'h00) instr = r_ins(rs, rt, rd, fns[$urandom_range(0, 8)]);
            else if (sel == 11 && $urandom_range(0, 1) == 1) instr = i_ins(6'h05, rs, rt, imm);
            else instr = i_ins(opcs[sel], rs, rt, imm);
            rs_data    = $urandom;
            rt_data    = $urandom;
            stall      = ($urandom_range(0, 9) == 0);
            flush      = ($urandom_range(0, 15) == 0);
            exmem_we   = $urandom_range(0, 1) == 1;
            exmem_rd   = 5'($urandom_range(0, 7));
            exmem_data = $urandom;
            memwb_we   = $urandom_range(0, 1) == 1;
            memwb_rd   = 5'($urandom_range(0, 7));
            memwb_data = $urandom;
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
